rr_mux_arbiter: RTL and testbench

Upstream control stage for mux_Nx1. It arbitrates round-robin among N valid/ready requesters and drives the select of an internal mux_Nx1 instance. The selected WIDTH-bit word is captured in a one-entry output register with a valid/ready handshake. It converts the static N:1 mux into a fair, flow-controlled N-to-1 channel merger.

---
 rtl/rr_mux_arbiter.sv | 104 ++++++++++
 tb/tb_rr_mux_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_mux_arbiter.sv
// Round-robin N-to-1 channel merger: arbitrates valid/ready requesters, steers the
// winning lane through an N:1 mux and captures it in a one-entry output register.

module mux_Nx1 #(
  parameter  int N         = 8,
  parameter  int WIDTH     = 8,
  localparam int SEL_WIDTH = $clog2(N)
) (
  input  logic [SEL_WIDTH-1:0] sel_i,
  input  logic [N*WIDTH-1:0]   data_i,
  output logic [WIDTH-1:0]     data_o
);

  // Equality-gated selection so unknowns on unselected lanes never leak through.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_i == SEL_WIDTH'(i)) data_o = data_i[i*WIDTH +: WIDTH];
    end
  end

endmodule

module rr_mux_arbiter #(
  parameter  int N         = 8,
  parameter  int WIDTH     = 8,
  localparam int SEL_WIDTH = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_WIDTH-1:0] out_sel
);

  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic                 out_valid_q;
  logic [WIDTH-1:0]     out_data_q;
  logic [SEL_WIDTH-1:0] out_sel_q;

  logic [SEL_WIDTH-1:0] grant;
  logic                 found;
  logic                 load;
  logic                 xfer;
  logic [WIDTH-1:0]     mux_out;

  // Circular search starting at ptr; the wrap is done explicitly so that
  // non-power-of-2 N never yields an index >= N.
  always_comb begin
    int idx;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (!found && in_valid[idx]) begin
        grant = SEL_WIDTH'(idx);
        found = 1'b1;
      end
    end
  end

  assign load  = !out_valid_q || out_ready;
  assign xfer  = load && found && !rst;
  assign ptr_d = (grant == SEL_WIDTH'(N-1)) ? '0 : grant + SEL_WIDTH'(1);

  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign in_ready[gi] = xfer && (grant == SEL_WIDTH'(gi));
  end

  mux_Nx1 #(
    .N     (N),
    .WIDTH (WIDTH)
  ) u_mux (
    .sel_i  (grant),
    .data_i (in_data),
    .data_o (mux_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= mux_out;
      out_sel_q   <= grant;
      ptr_q       <= ptr_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed steps from the test plan plus
// randomized traffic against a transaction-level model, and an N=5 instance.

module tb_rr_mux_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // N=8 instance
  logic        rst;
  logic [7:0]  in_valid, in_ready;
  logic [63:0] in_data;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic [2:0]  out_sel;

  rr_mux_arbiter #(.N(8), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  // N=5 instance
  logic        rst5;
  logic [4:0]  in_valid5, in_ready5;
  logic [39:0] in_data5;
  logic        out_valid5, out_ready5;
  logic [7:0]  out_data5;
  logic [2:0]  out_sel5;

  rr_mux_arbiter #(.N(5), .WIDTH(8)) dut5 (
    .clk       (clk),
    .rst       (rst5),
    .in_valid  (in_valid5),
    .in_ready  (in_ready5),
    .in_data   (in_data5),
    .out_valid (out_valid5),
    .out_ready (out_ready5),
    .out_data  (out_data5),
    .out_sel   (out_sel5)
  );

  localparam logic [63:0] LANES = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44};

  int tests = 0;
  int fails = 0;

  // Reference model: one output slot and a priority index
  logic       m_valid = 1'b0;
  logic [7:0] m_data  = '0;
  int         m_sel   = 0;
  int         m_ptr   = 0;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // First valid requester met when walking the ring from p
  function automatic int model_grant(input logic [7:0] v, input int p);
    for (int k = 0; k < 8; k++) begin
      if (v[(p + k) % 8] === 1'b1) return (p + k) % 8;
    end
    return -1;
  endfunction

  // One clock of the N=8 DUT checked against the model
  task automatic cycle8();
    int         g;
    logic       accept;
    logic [7:0] exp_ready;
    #1;
    g         = model_grant(in_valid, m_ptr);
    accept    = !rst && (!m_valid || out_ready) && (g >= 0);
    exp_ready = '0;
    if (accept) exp_ready[g] = 1'b1;
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    end else if (accept) begin
      m_valid = 1'b1; m_data = in_data[g*8 +: 8]; m_sel = g; m_ptr = (g + 1) % 8;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_sel",   32'(out_sel),   32'(m_sel));
    $display("[TB] t=%0t rst=%b v=%h rdy=%b -> ov=%b sel=%0d data=%h",
             $time, rst, in_valid, out_ready, out_valid, out_sel, out_data);
  endtask

  initial begin
    rst = 1'b1; in_valid = 8'hFF; out_ready = 1'b1; in_data = LANES;
    rst5 = 1'b1; in_valid5 = '0; out_ready5 = 1'b1;
    in_data5 = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

    // Reset held for two edges with every requester valid
    cycle8();
    cycle8();
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_sel", 32'(out_sel), 32'h0);
    rst = 1'b0;
    cycle8();
    check("first_grant_data", 32'(out_data), 32'h44);

    // Single requester, then idle, then ptr inferred from the next grant
    in_valid = 8'b0000_0100;
    cycle8();
    check("single_sel", 32'(out_sel), 32'd2);
    check("single_data", 32'(out_data), 32'h22);
    in_valid = 8'h00;
    cycle8();
    check("single_drain", 32'(out_valid), 32'h0);
    in_valid = 8'hFF;
    cycle8();
    check("ptr_after_single", 32'(out_sel), 32'd3);

    // Full round-robin from a fresh reset
    rst = 1'b1;
    cycle8();
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      cycle8();
      check("rr_sel", 32'(out_sel), 32'(k % 8));
      check("rr_valid", 32'(out_valid), 32'h1);
    end

    // Backpressure on lane 5, then wrap to lanes 0 and 1
    in_valid = 8'b0010_0000;
    cycle8();
    check("bp_grant_sel", 32'(out_sel), 32'd5);
    out_ready = 1'b0; in_valid = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      cycle8();
      check("bp_hold_data", 32'(out_data), 32'hCC);
      check("bp_hold_ready", 32'(in_ready), 32'h0);
    end
    in_valid = 8'b0000_0011; out_ready = 1'b1;
    cycle8();
    check("wrap_data0", 32'(out_data), 32'h44);
    cycle8();
    check("wrap_data1", 32'(out_data), 32'h33);

    // Reset while a word is stalled in the output slot
    in_valid = 8'b0001_0000;
    cycle8();
    check("mid_pre_sel", 32'(out_sel), 32'd4);
    out_ready = 1'b0; rst = 1'b1; in_valid = 8'hFF;
    cycle8();
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_sel", 32'(out_sel), 32'h0);
    rst = 1'b0; out_ready = 1'b1;
    cycle8();
    check("mid_post_sel", 32'(out_sel), 32'd0);

    // Unknowns on non-granted lanes must not reach out_data
    in_valid = 8'b0000_1000;
    in_data  = {{32{1'bx}}, 8'h11, {24{1'bx}}};
    cycle8();
    check("x_lane_data", 32'(out_data), 32'h11);
    in_data = LANES;

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      in_valid  = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      cycle8();
    end

    // Non-power-of-2 ring
    rst5 = 1'b0; in_valid5 = 5'h1F; out_ready5 = 1'b1;
    #1;
    check("n5_in_ready", 32'(in_ready5), 32'h01);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      check("n5_sel", 32'(out_sel5), 32'(k % 5));
      check("n5_data", 32'(out_data5), 32'(8'h11 * ((k % 5) + 1)));
      check("n5_sel_range", 32'(out_sel5 < 3'd5), 32'h1);
      $display("[TB] n5 t=%0t sel=%0d data=%h", $time, out_sel5, out_data5);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
